// File: rtl/clk_div_cfg.sv
// Glitch-safe reconfiguration sequencer for a downstream clock divider.
// The enable is gated off around every ratio change, so the ratio only moves while the divider is stopped.
module clk_div_cfg #(
    parameter int RATIO_WIDTH   = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    input  logic [RATIO_WIDTH-1:0] i_req_ratio,
    input  logic                   i_req_en,
    output logic                   o_req_ready,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_clk_en,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_bypass
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        LOAD   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [RATIO_WIDTH-1:0] r_pend_ratio;
    logic                   r_pend_en;
    logic [RATIO_WIDTH-1:0] r_div_ratio;
    logic                   r_clk_en;
    logic                   r_done;

    logic w_accept;
    logic w_same;

    assign w_accept = i_req_valid && o_req_ready;
    assign w_same   = (i_req_ratio == r_div_ratio) && (i_req_en == r_clk_en);

    // NOTE: all state below updates with <=, so every branch sees the values from before this edge.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_pend_ratio <= '0;
            r_pend_en    <= 1'b0;
            r_div_ratio  <= '0;
            r_clk_en     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pend_ratio <= i_req_ratio;
                        r_pend_en    <= i_req_en;
                        if (w_same) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state  <= GATE;
                            r_clk_en <= 1'b0;
                            r_cnt    <= '0;
                        end
                    end
                end
                GATE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    r_div_ratio <= r_pend_ratio;
                    r_cnt       <= '0;
                    r_state     <= SETTLE;
                end
                SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_clk_en <= r_pend_en;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == IDLE) && !i_rst;
    assign o_busy      = (r_state != IDLE);
    assign o_div_ratio = r_div_ratio;
    assign o_clk_en    = r_clk_en;
    assign o_done      = r_done;
    assign o_bypass    = (r_div_ratio < RATIO_WIDTH'(2)) || !r_clk_en;

endmodule

// File: tb/tb_clk_div_cfg.sv
// Self-checking bench for clk_div_cfg: a schedule-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_clk_div_cfg;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [W-1:0] req_ratio = '0;
    logic         req_en = 1'b0;
    logic         req_ready;
    logic [W-1:0] div_ratio;
    logic         clk_en;
    logic         busy;
    logic         done;
    logic         bypass;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    clk_div_cfg #(.RATIO_WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .i_ref_clk  (clk),
        .i_rst      (rst),
        .i_req_valid(req_valid),
        .i_req_ratio(req_ratio),
        .i_req_en   (req_en),
        .o_req_ready(req_ready),
        .o_div_ratio(div_ratio),
        .o_clk_en   (clk_en),
        .o_busy     (busy),
        .o_done     (done),
        .o_bypass   (bypass)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timestamps each accepted request and applies the ratio and
    // enable updates at their fixed offsets from the acceptance edge.
    logic [W-1:0] m_ratio, m_p_ratio;
    logic         m_en, m_p_en, m_done, m_in_seq;
    int           m_age;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ratio   <= '0;
            m_en      <= 1'b0;
            m_done    <= 1'b0;
            m_in_seq  <= 1'b0;
            m_p_ratio <= '0;
            m_p_en    <= 1'b0;
            m_age     <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_in_seq) begin
                m_age <= m_age + 1;
                if (m_age == S + 1) m_ratio <= m_p_ratio;
                if (m_age == 2 * S + 1) begin
                    m_en     <= m_p_en;
                    m_done   <= 1'b1;
                    m_in_seq <= 1'b0;
                end
            end else if (req_valid) begin
                if (req_ratio == m_ratio && req_en == m_en) begin
                    m_done <= 1'b1;
                end else begin
                    m_in_seq  <= 1'b1;
                    m_age     <= 1;
                    m_en      <= 1'b0;
                    m_p_ratio <= req_ratio;
                    m_p_en    <= req_en;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_ratio",  div_ratio, m_ratio);
            check("cyc_clk_en", clk_en,    m_en);
            check("cyc_done",   done,      m_done);
            check("cyc_busy",   busy,      m_in_seq);
            check("cyc_ready",  req_ready, !m_in_seq && !rst);
            check("cyc_bypass", bypass,    (m_ratio < 2) || !m_en);
        end
    end

    // Presents a request and holds it until an edge accepts it (ready high before that edge).
    task automatic send(input logic [W-1:0] ratio, input logic en);
        bit ok = 1'b0;
        @(negedge clk); #1;
        req_valid = 1'b1;
        req_ratio = ratio;
        req_en    = en;
        for (int i = 0; i < 60; i++) begin
            logic rdy;
            rdy = req_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        #1 req_valid = 1'b0;
        check("accept_within_budget", ok, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_within_budget", ok, 1'b1);
    endtask

    initial begin
        #12;
        check("rst_ratio",  div_ratio, 0);
        check("rst_ready",  req_ready, 0);
        check("rst_busy",   busy,      0);
        check("rst_bypass", bypass,    1);
        @(negedge clk); #1 rst = 1'b0;
        #1 check("ready_after_release", req_ready, 1);
        cmp_on = 1'b1;

        // ratio=6 en=1: ratio visible after edge 5, enable and done after edge 9
        send(8'd6, 1'b1);
        check("seq_busy_e0",  busy,   1);
        check("seq_clken_e0", clk_en, 0);
        repeat (4) @(posedge clk);
        #1 check("ratio_before_e5", div_ratio, 0);
        check("ready_e4", req_ready, 0);
        @(posedge clk); #1;
        check("ratio_after_e5",  div_ratio, 6);
        check("clken_after_e5",  clk_en,    0);
        check("bypass_after_e5", bypass,    1);
        repeat (3) @(posedge clk);
        #1 check("ready_e8", req_ready, 0);
        @(posedge clk); #1;
        check("clken_after_e9",  clk_en,    1);
        check("done_after_e9",   done,      1);
        check("bypass_after_e9", bypass,    0);
        check("ready_after_e9",  req_ready, 1);

        // Identical request: done one cycle later, never busy
        send(8'd6, 1'b1);
        check("same_done",  done,   1);
        check("same_busy",  busy,   0);
        check("same_clken", clk_en, 1);

        // ratio=3 held while busy with ratio=6
        send(8'd6, 1'b0);
        send(8'd3, 1'b1);
        wait_idle();
        check("held_ratio", div_ratio, 3);
        check("held_clken", clk_en,    1);

        // Ratio 1 passes through and flags bypass
        send(8'd1, 1'b1);
        wait_idle();
        check("r1_ratio",  div_ratio, 1);
        check("r1_clken",  clk_en,    1);
        check("r1_bypass", bypass,    1);

        // Reset during SETTLE clears outputs without a clock edge
        send(8'd5, 1'b1);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("settle_rst_ratio",  div_ratio, 0);
        check("settle_rst_clken",  clk_en,    0);
        check("settle_rst_done",   done,      0);
        check("settle_rst_busy",   busy,      0);
        check("settle_rst_bypass", bypass,    1);
        check("settle_rst_ready",  req_ready, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Reset in GATE cycle 2 drops the request
        send(8'd8, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("gate_rst_ratio", div_ratio, 0);
        check("gate_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("gate_rst_no_done", done, 0);
        end
        check("gate_rst_ratio_kept", div_ratio, 0);

        send(8'd4, 1'b1);
        wait_idle();
        check("post_rst_ratio", div_ratio, 4);
        check("post_rst_clken", clk_en,    1);

        repeat (2) @(negedge clk);
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_cfg.md
CLK_DIV_CFG -- requirements
Module: clk_div_cfg

Interface
REQ-001 SHALL have parameter RATIO_WIDTH, default 8, width of the division ratio.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, gate-off cycles before and after a ratio load; legal range 1..255.
REQ-003 SHALL have port i_ref_clk  in  1  the single clock; all flops on its rising edge.
REQ-004 SHALL have port i_rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_req_valid  in  1  a reconfiguration request is presented.
REQ-006 SHALL have port i_req_ratio  in  RATIO_WIDTH  requested division ratio.
REQ-007 SHALL have port i_req_en  in  1  requested divider enable after the update.
REQ-008 SHALL have port o_req_ready  out  1  the block can accept a request this cycle.
REQ-009 SHALL have port o_div_ratio  out  RATIO_WIDTH  registered ratio driven to the downstream clock divider.
REQ-010 SHALL have port o_clk_en  out  1  registered enable driven to the downstream clock divider.
REQ-011 SHALL have port o_busy  out  1  a reconfiguration sequence is in progress.
REQ-012 SHALL have port o_done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port o_bypass  out  1  the divider passes the reference clock: o_div_ratio < 2 or o_clk_en = 0.

Function
REQ-014 SHALL implement FSM states IDLE, GATE, LOAD, SETTLE.
REQ-015 SHALL drive o_req_ready = (state == IDLE) and not i_rst.
REQ-016 SHALL drive o_busy = (state != IDLE).
REQ-017 SHALL accept a request on a rising edge with i_req_valid = 1 and o_req_ready = 1, and capture i_req_ratio and i_req_en into pending registers.
REQ-018 SHALL require the requester to hold i_req_valid and the request data stable until acceptance.
REQ-019 SHALL ignore i_req_valid while o_req_ready = 0: no capture and no side effect.
REQ-020 SHALL, on accepting a request equal to the current {o_div_ratio, o_clk_en}, stay in IDLE, leave both outputs unchanged, and pulse o_done in the next cycle.
REQ-021 SHALL, on any other accepted request, go to GATE, clear o_clk_en on the same edge, and clear the settle counter.
REQ-022 SHALL keep GATE for exactly SETTLE_CYCLES cycles, then go to LOAD.
REQ-023 SHALL, in LOAD for one cycle, write the pending ratio to o_div_ratio on the exiting edge, clear the counter, and go to SETTLE.
REQ-024 SHALL keep SETTLE for exactly SETTLE_CYCLES cycles with o_clk_en = 0.
REQ-025 SHALL, on the last SETTLE edge, load the pending enable into o_clk_en, set o_done for exactly one cycle, and return to IDLE.
REQ-026 SHALL, with acceptance at edge 0, update o_div_ratio after edge SETTLE_CYCLES+1, and update o_clk_en and assert o_done after edge 2*SETTLE_CYCLES+1.
REQ-027 SHALL raise o_req_ready in the same cycle o_done is high, so a back-to-back request can be accepted on the next edge.
REQ-028 SHALL pass ratios 0 and 1 unchanged to o_div_ratio; this case is flagged only through o_bypass.
REQ-029 SHALL size the settle counter at clog2(SETTLE_CYCLES+1) bits, with no wrap inside one phase.
REQ-030 SHALL keep o_div_ratio stable at all times except the LOAD exit edge.
REQ-031 SHALL change o_div_ratio only while o_clk_en = 0.
REQ-032 SHALL derive o_bypass combinationally from the o_div_ratio and o_clk_en registers only.

Reset
REQ-033 SHALL, on i_rst high at any time including mid-sequence, immediately force: state IDLE, o_div_ratio 0, o_clk_en 0, o_done 0, counter 0, pending registers 0.
REQ-034 SHALL, as a result of reset, present o_busy 0, o_bypass 1, o_req_ready 0.
REQ-035 SHALL, when reset aborts an in-flight request, drop that request and never report it via o_done.
REQ-036 SHALL assert o_req_ready from the first clock cycle after i_rst is released.

Verification
REQ-037 SHALL cover: assert i_rst during SETTLE -> o_div_ratio=0, o_clk_en=0, o_done=0, o_busy=0, o_bypass=1 with no clock edge required.
REQ-038 SHALL cover: after reset, SETTLE_CYCLES=4, request ratio=6, en=1 at edge 0 -> o_req_ready low for edges 1..9; o_div_ratio=6 after edge 5; o_clk_en=1 and o_done=1 after edge 9; o_bypass falls with o_clk_en.
REQ-039 SHALL cover: repeat request ratio=6, en=1 -> o_done pulse one cycle later; o_busy never high; o_clk_en stays 1.
REQ-040 SHALL cover: request ratio=3 held valid while busy with ratio=6 -> not accepted until o_req_ready returns; then a full second sequence ends with o_div_ratio=3.
REQ-041 SHALL cover: request ratio=1, en=1 -> full sequence runs; ends with o_clk_en=1 and o_bypass=1.
REQ-042 SHALL cover: request ratio=8, then i_rst pulse at GATE cycle 2 -> o_div_ratio stays 0; no o_done; the next request after reset completes normally.
